// File: rtl/data_rx_sequencer_if.sv
// Receive-side bundle between the unstuffer/PID decoder, the CRC16 checker,
// the protocol handler and the DATA0 sequencer.
interface data_rx_sequencer_if #(
    parameter int unsigned DATA_BITS = 64
);
    logic                 pid_ok;
    logic                 bit_valid;
    logic                 bit_in;
    logic                 eop;
    logic [15:0]          crc_residue;
    logic                 crc_clr;
    logic                 crc_en;
    logic [DATA_BITS-1:0] data;
    logic                 pkt_done;
    logic                 crc_ok;
    logic                 len_err;
    logic                 timeout_err;
    logic                 busy;

    modport slave (
        input  pid_ok, bit_valid, bit_in, eop, crc_residue,
        output crc_clr, crc_en, data, pkt_done, crc_ok, len_err, timeout_err, busy
    );

    modport master (
        output pid_ok, bit_valid, bit_in, eop, crc_residue,
        input  crc_clr, crc_en, data, pkt_done, crc_ok, len_err, timeout_err, busy
    );
endinterface

// File: rtl/data_rx_sequencer.sv
// DATA0 receive sequencer: streams body bits into the CRC16 checker, buffers
// them, and judges length and residue on EOP or aborts on inter-bit timeout.
module data_rx_sequencer #(
    parameter int unsigned DATA_BITS      = 64,
    parameter int unsigned CRC_BITS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] RESIDUE        = 16'h800D
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_rx_sequencer_if.slave rx
);
    localparam int unsigned W  = DATA_BITS + CRC_BITS;
    localparam int unsigned CW = $clog2(W + 2);
    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    state_t               state_q;
    logic [W-1:0]         buf_q, buf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 pkt_done_q;
    logic                 crc_ok_q;
    logic                 len_err_q;
    logic                 timeout_err_q;
    logic                 check_good;

    // A restart pid_ok wins over a same-cycle bit, so that bit never reaches the checker.
    assign rx.crc_en      = (state_q == RECV) && !rx.pid_ok && rx.bit_valid;
    assign rx.crc_clr     = rx.pid_ok && ((state_q == IDLE) || (state_q == RECV));
    assign rx.busy        = (state_q != IDLE);
    assign rx.data        = data_q;
    assign rx.pkt_done    = pkt_done_q;
    assign rx.crc_ok      = crc_ok_q;
    assign rx.len_err     = len_err_q;
    assign rx.timeout_err = timeout_err_q;

    assign check_good = (cnt_q == CNT_FULL) && (rx.crc_residue == RESIDUE);

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        gap_d = gap_q;
        if (rx.bit_valid) begin
            buf_d = {rx.bit_in, buf_q[W-1:1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            cnt_q         <= '0;
            gap_q         <= '0;
            data_q        <= '0;
            pkt_done_q    <= 1'b0;
            crc_ok_q      <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx.pid_ok) begin
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (rx.pid_ok) begin
                        cnt_q <= '0;
                        gap_q <= '0;
                        buf_q <= '0;
                    end else if (rx.eop) begin
                        buf_q   <= buf_d;
                        cnt_q   <= cnt_d;
                        gap_q   <= gap_d;
                        state_q <= CHECK;
                    end else if (!rx.bit_valid && (gap_q == GAP_LAST)) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                        state_q       <= IDLE;
                        pkt_done_q    <= 1'b1;
                        timeout_err_q <= 1'b1;
                        crc_ok_q      <= 1'b0;
                        len_err_q     <= 1'b0;
                    end else begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        gap_q <= gap_d;
                    end
                end
                CHECK: begin
                    len_err_q     <= (cnt_q != CNT_FULL);
                    crc_ok_q      <= check_good;
                    timeout_err_q <= 1'b0;
                    pkt_done_q    <= 1'b1;
                    if (check_good) begin
                        data_q <= buf_q[DATA_BITS-1:0];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_rx_sequencer.sv
// Directed bench for data_rx_sequencer with a serial CRC16 checker model
// driving crc_residue from the sequencer's crc_clr/crc_en.
module tb_data_rx_sequencer;
    localparam int unsigned T = 255;
    localparam logic [63:0] P  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m_crc = 16'h0000;
    int          pkt_cnt = 0;
    int          en_cnt = 0;
    int          n_total = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    data_rx_sequencer_if #(.DATA_BITS(64)) rx ();

    data_rx_sequencer #(
        .DATA_BITS     (64),
        .CRC_BITS      (16),
        .TIMEOUT_CYCLES(T),
        .RESIDUE       (16'h800D)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx   (rx)
    );

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction

    function automatic logic [15:0] crc_of(input logic [63:0] pay);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) c = crc_step(c, pay[i]);
        return c;
    endfunction

    // Checker remainder register, updated on the edge after crc_en.
    always @(posedge clk) begin
        if (rx.crc_clr) m_crc <= 16'hFFFF;
        else if (rx.crc_en) m_crc <= crc_step(m_crc, rx.bit_in);
    end
    assign rx.crc_residue = m_crc;

    always @(negedge clk) begin
        if (rx.pkt_done) pkt_cnt <= pkt_cnt + 1;
        if (rx.crc_en) en_cnt <= en_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // mode 0: eop after last bit; 1: eop with last bit; 2: no eop
    task automatic send_pkt(input logic [63:0] pay, input int nbits, input int flip,
                            input bit gaps, input int mode);
        logic [95:0] pk;
        logic [15:0] c;
        c  = crc_of(pay);
        pk = '0;
        pk[63:0] = pay;
        for (int i = 0; i < 16; i++) pk[64+i] = ~c[15-i];
        if (flip >= 0) pk[flip] = ~pk[flip];
        rx.pid_ok    = 1'b1;
        rx.bit_valid = 1'b1;
        rx.bit_in    = 1'b1;
        #1;
        chk("start_crc_clr", 64'(rx.crc_clr), 64'd1);
        chk("start_no_crc_en", 64'(rx.crc_en), 64'd0);
        step();
        rx.pid_ok    = 1'b0;
        rx.bit_valid = 1'b0;
        chk("start_busy", 64'(rx.busy), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                rx.bit_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            rx.bit_valid = 1'b1;
            rx.bit_in    = pk[i];
            if (mode == 1 && i == nbits - 1) rx.eop = 1'b1;
            step();
        end
        rx.bit_valid = 1'b0;
        rx.eop       = 1'b0;
        if (mode == 0) begin
            rx.eop = 1'b1;
            step();
            rx.eop = 1'b0;
        end
    endtask

    typedef struct {
        logic [63:0] payload;
        int          nbits;
        int          flip;
        bit          gaps;
        int          mode;
        logic        exp_ok;
        logic        exp_len;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e0, p0;
        vecs[0] = '{P,  80, -1, 1'b0, 0, 1'b1, 1'b0, P};
        vecs[1] = '{P,  80, -1, 1'b1, 0, 1'b1, 1'b0, P};
        vecs[2] = '{D2, 80, -1, 1'b1, 0, 1'b1, 1'b0, D2};
        vecs[3] = '{P,  80, 17, 1'b0, 0, 1'b0, 1'b0, D2};
        vecs[4] = '{P,  79, -1, 1'b0, 0, 1'b0, 1'b1, D2};
        vecs[5] = '{P,  81, -1, 1'b0, 0, 1'b0, 1'b1, D2};
        vecs[6] = '{P,  80, -1, 1'b0, 1, 1'b1, 1'b0, P};

        rx.pid_ok = 1'b0; rx.bit_valid = 1'b0; rx.bit_in = 1'b0; rx.eop = 1'b0;
        rst = 1'b1;
        step(); step();
        chk("rst_pkt_done", 64'(rx.pkt_done), 64'd0);
        chk("rst_busy", 64'(rx.busy), 64'd0);
        chk("rst_data", rx.data, 64'd0);
        chk("rst_flags", {61'd0, rx.crc_ok, rx.len_err, rx.timeout_err}, 64'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            e0 = en_cnt;
            send_pkt(vecs[v].payload, vecs[v].nbits, vecs[v].flip, vecs[v].gaps, vecs[v].mode);
            chk($sformatf("v%0d_check_busy", v), 64'(rx.busy), 64'd1);
            chk($sformatf("v%0d_no_early_done", v), 64'(rx.pkt_done), 64'd0);
            step();
            chk($sformatf("v%0d_pkt_done", v), 64'(rx.pkt_done), 64'd1);
            chk($sformatf("v%0d_crc_ok", v), 64'(rx.crc_ok), 64'(vecs[v].exp_ok));
            chk($sformatf("v%0d_len_err", v), 64'(rx.len_err), 64'(vecs[v].exp_len));
            chk($sformatf("v%0d_timeout_err", v), 64'(rx.timeout_err), 64'd0);
            chk($sformatf("v%0d_data", v), rx.data, vecs[v].exp_data);
            chk($sformatf("v%0d_idle", v), 64'(rx.busy), 64'd0);
            chk($sformatf("v%0d_crc_en_count", v), 64'(en_cnt - e0), 64'(vecs[v].nbits));
        end

        // Inter-bit timeout after 40 bits.
        step();
        p0 = pkt_cnt;
        send_pkt(D2, 40, -1, 1'b0, 2);
        repeat (T - 1) step();
        chk("to_not_yet", 64'(rx.pkt_done), 64'd0);
        chk("to_still_busy", 64'(rx.busy), 64'd1);
        step();
        chk("to_pkt_done", 64'(rx.pkt_done), 64'd1);
        chk("to_flags", {61'd0, rx.crc_ok, rx.len_err, rx.timeout_err}, 64'd1);
        chk("to_busy", 64'(rx.busy), 64'd0);
        chk("to_data_held", rx.data, P);
        step();
        chk("to_pulse_once", 64'(rx.pkt_done), 64'd0);
        chk("to_flag_hold", 64'(rx.timeout_err), 64'd1);
        chk("to_done_count", 64'(pkt_cnt - p0), 64'd1);

        // Restart after 30 bits, then a full good packet.
        p0 = pkt_cnt;
        send_pkt(P, 30, -1, 1'b0, 2);
        send_pkt(D2, 80, -1, 1'b0, 0);
        step();
        chk("rs_pkt_done", 64'(rx.pkt_done), 64'd1);
        chk("rs_crc_ok", 64'(rx.crc_ok), 64'd1);
        chk("rs_data", rx.data, D2);
        step();
        chk("rs_done_count", 64'(pkt_cnt - p0), 64'd1);

        // Reset in the middle of a packet.
        p0 = pkt_cnt;
        send_pkt(P, 50, -1, 1'b0, 2);
        rst = 1'b1;
        step();
        chk("mr_busy", 64'(rx.busy), 64'd0);
        chk("mr_data", rx.data, 64'd0);
        chk("mr_flags", {60'd0, rx.pkt_done, rx.crc_ok, rx.len_err, rx.timeout_err}, 64'd0);
        chk("mr_crc_ctl", {62'd0, rx.crc_clr, rx.crc_en}, 64'd0);
        rst = 1'b0;
        repeat (5) step();
        chk("mr_no_done", 64'(pkt_cnt - p0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_rx_sequencer.md
# data_rx_sequencer

Receive-side sequencer for USB DATA0 packets. Sits between the bit-unstuffer/PID decoder and the CRC16 checker. After a DATA0 PID it:
- streams the unstuffed payload and CRC bits into the checker, pausing across stuffed-bit gaps;
- counts and buffers the bits;
- on EOP, judges packet length and CRC residue.

It delivers the 64-bit payload plus a one-cycle completion pulse with status flags to the protocol handler.

## Interface
- DATA_BITS, 64, payload bits per packet
- CRC_BITS, 16, CRC bits following the payload
- TIMEOUT_CYCLES, 255, maximum idle cycles between valid bits inside a packet (≥2)
- RESIDUE, 16'h800D, good-packet CRC16 residue
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- pid_ok  in  1  one-cycle pulse: DATA0 PID accepted; packet body starts on a later cycle
- bit_valid  in  1  bit_in carries an unstuffed body bit this cycle (stuffed bits are never flagged)
- bit_in  in  1  body bit, LSB-first as on the wire
- eop  in  1  one-cycle pulse: end of packet seen
- crc_residue  in  16  checker remainder register (updates on the edge after crc_en)
- crc_clr  out  1  re-seed checker to all ones
- crc_en  out  1  checker consumes bit_in this cycle
- data  out  DATA_BITS  payload of the last good packet
- pkt_done  out  1  one-cycle completion pulse
- crc_ok  out  1  last packet good (length and residue)
- len_err  out  1  last packet bit count ≠ DATA_BITS+CRC_BITS
- timeout_err  out  1  last packet aborted by inter-bit timeout
- busy  out  1  packet in progress (state ≠ IDLE)

## Operation
- State machine has three states: IDLE, RECV, CHECK.
- **IDLE**
  - On pid_ok: crc_clr=1 (combinational, this cycle); clear bit count and gap counter; go to RECV.
  - All other inputs are ignored.
- **RECV**
  - When bit_valid=1:
    - crc_en=1 (combinational, same cycle).
    - Shift buffer: buf ← {bit_in, buf[W-1:1]}, with W = DATA_BITS+CRC_BITS. After exactly W bits, the first received bit is at buf[0].
    - Bit count increments, saturating at W+1.
    - Gap counter clears.
  - When bit_valid=0: gap counter increments.
  - crc_en is never asserted outside RECV.
- **RECV exits** (checked in this priority order)
  1. pid_ok → restart. crc_clr=1; count, gap and buf are cleared; stay in RECV; no pkt_done. A bit_valid in the same cycle is dropped.
  2. eop → CHECK. A bit_valid in the same cycle is accepted first.
  3. Gap counter reaching TIMEOUT_CYCLES → IDLE, registering pkt_done=1, timeout_err=1, crc_ok=0, len_err=0.
- **CHECK** (one cycle; residue now reflects every accepted bit)
  - len_err ← (count ≠ W).
  - crc_ok ← (count = W) && (crc_residue = RESIDUE).
  - timeout_err ← 0.
  - pkt_done ← 1.
  - If crc_ok, data ← buf[DATA_BITS-1:0]; otherwise data holds its previous value.
  - Next state IDLE. A pid_ok arriving in CHECK is ignored.
- **Status outputs**
  - crc_ok, len_err and timeout_err are registered.
  - They change only in the cycle pkt_done is high and hold until the next pkt_done.
  - Exactly one of {crc_ok, len_err, timeout_err, CRC-bad} describes each packet. CRC-bad means all three flags are 0.
- **Widths**
  - Bit counter is $clog2(W+2) bits wide.
  - Gap counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.

## Timing
- **Reset:** state=IDLE; buf=0; data=0; counters=0; pkt_done, crc_ok, len_err, timeout_err, busy, crc_clr and crc_en all 0.
- **Reset mid-packet:** the packet is dropped silently, with no pkt_done.
- **Start:** pid_ok at cycle N gives crc_clr=1 at N and busy=1 from N+1.
  - A body bit is accepted at N+1 at the earliest.
  - A bit_valid at N itself is ignored.
- **Normal completion:** eop at cycle N gives CHECK at N+1, then at N+2:
  - pkt_done=1;
  - status and data valid;
  - busy=0.
- **Timeout:** the gap counter reaches TIMEOUT_CYCLES at cycle N (the TIMEOUT_CYCLES-th consecutive cycle without bit_valid). Then pkt_done=1 and timeout_err=1 at N+1, and busy=0 at N+1.
- **Throughput:** back-to-back packets are supported. pid_ok is accepted from the cycle pkt_done is high.

## Test plan
- **Good packet:** pid_ok, then 64 payload bits of 64'h0123_4567_89AB_CDEF LSB-first plus their correct CRC16, then eop. crc_residue is driven by the reference CRC16 model. Expect pkt_done one cycle, crc_ok=1, len_err=0, data=64'h0123_4567_89AB_CDEF, pkt_done two cycles after eop.
- **Stuffed gaps:** same packet with bit_valid low for 1–3 cycles between random bits. Expect the identical result, and a crc_en count of exactly 80.
- **Corrupt CRC:** flip payload bit 17 of a good packet after a prior good packet left data=D. Expect crc_ok=0, len_err=0, timeout_err=0, data=D unchanged.
- **Length errors:**
  - 79 bits then eop → len_err=1, crc_ok=0.
  - 81 bits then eop → len_err=1.
  - eop together with the 80th bit_valid → crc_ok=1.
- **Timeout:** stop after 40 bits with no eop. Expect pkt_done with timeout_err=1 exactly TIMEOUT_CYCLES+1 cycles after the last bit_valid, then busy=0.
- **Restart/reset:**
  - pid_ok after 30 bits, then a full good packet → exactly one pkt_done, with crc_ok=1.
  - reset asserted after 50 bits → all outputs 0 next cycle and no pkt_done.
